// File: rtl/aes_pkg.sv
// Shared types and constants for the AES output serializer.
package aes_pkg;

    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;

    // IDLE: active store empty; SEND: active store occupied and being serialized.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/aes_output_buffer.sv
// Serializes 128-bit AES result blocks into four 32-bit words with a
// valid/ready handshake, buffering one extra block while the current one drains.
//
//   state | meaning
//   IDLE  | active store empty, waiting for done_i
//   SEND  | active store occupied, emitting word[index]
module aes_output_buffer
    import aes_pkg::*;
#(
    parameter int LSW_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                done_i,
    input  logic [BLOCK_W-1:0]  text_i,
    input  logic                ready_i,
    output logic [WORD_W-1:0]   text_o,
    output logic                valid_o,
    output logic                last_o,
    output logic                busy_o,
    output logic                ovf_o
);

    state_t               state, state_n;
    logic [1:0]           idx, idx_n;
    logic [BLOCK_W-1:0]   active, active_n;
    logic [BLOCK_W-1:0]   pending, pending_n;
    logic                 pend_full, pend_full_n;
    logic                 ovf, ovf_n;

    logic                 xfer;
    logic                 final_xfer;
    logic [1:0]           sel;
    logic [WORD_W-1:0]    word;

    assign xfer       = (state == SEND) && ready_i;
    assign final_xfer = xfer && (idx == 2'd3);

    // Outputs come only from registered state, so ready_i/done_i never reach valid_o/busy_o.
    assign valid_o = (state == SEND);
    assign last_o  = valid_o && (idx == 2'd3);
    assign busy_o  = (state == SEND) || pend_full;
    assign ovf_o   = ovf;

    // Word select: index counts transfers; LSW_FIRST=0 walks from the top word down.
    always_comb begin
        sel  = (LSW_FIRST != 0) ? idx : (2'd3 - idx);
        word = '0;
        case (sel)
            2'd0: word = active[31:0];
            2'd1: word = active[63:32];
            2'd2: word = active[95:64];
            2'd3: word = active[127:96];
            default: word = '0;
        endcase
        text_o = valid_o ? word : '0;
    end

    // Next-state logic: load, queue, promote or drop incoming blocks.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        active_n    = active;
        pending_n   = pending;
        pend_full_n = pend_full;
        ovf_n       = ovf;
        case (state)
            IDLE: begin
                if (done_i) begin
                    active_n = text_i;
                    idx_n    = 2'd0;
                    state_n  = SEND;
                end
            end
            SEND: begin
                if (final_xfer) begin
                    idx_n = 2'd0;
                    if (pend_full) begin
                        // Promote the queued block with no bubble; refill the queue if a new one arrives.
                        active_n = pending;
                        if (done_i) pending_n = text_i;
                        else        pend_full_n = 1'b0;
                    end else if (done_i) begin
                        active_n = text_i;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    if (xfer) idx_n = idx + 2'd1;
                    if (done_i) begin
                        if (!pend_full) begin
                            pending_n   = text_i;
                            pend_full_n = 1'b1;
                        end else begin
                            ovf_n = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register with synchronous active-low reset; reset wins over done_i.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= 2'd0;
            active    <= '0;
            pending   <= '0;
            pend_full <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            active    <= active_n;
            pending   <= pending_n;
            pend_full <= pend_full_n;
            ovf       <= ovf_n;
        end
    end

endmodule

// File: doc/aes_output_buffer.md
AES_OUTPUT_BUFFER -- requirements
Module: aes_output_buffer

Interface
REQ-001 SHALL have parameter LSW_FIRST, default 1: 1 = emit text[31:0] first; 0 = emit text[127:96] first.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port done_i, input, 1 bit: single-cycle strobe from the AES core; text_i is valid this cycle.
REQ-005 SHALL have port text_i, input, 128 bits: result block from the AES core.
REQ-006 SHALL have port ready_i, input, 1 bit: downstream accepts the current word.
REQ-007 SHALL have port text_o, output, 32 bits: current output word.
REQ-008 SHALL have port valid_o, output, 1 bit: text_o holds a valid word.
REQ-009 SHALL have port last_o, output, 1 bit: the current word is the 4th word of its block.
REQ-010 SHALL have port busy_o, output, 1 bit: the active register or the pending register is occupied.
REQ-011 SHALL have port ovf_o, output, 1 bit: sticky flag; a block was dropped.

Function
REQ-012 SHALL hold two 128-bit stores: active (being serialized) and pending (one-deep queue), each with an occupied flag.
REQ-013 SHALL implement FSM IDLE (active empty) and SEND (active occupied), plus a 2-bit word index 0..3.
REQ-014 SHALL transfer a word in any cycle with valid_o && ready_i; index increments on each transfer.
REQ-015 SHALL drive text_o = active word[index], ordered per LSW_FIRST; text_o = 0 when valid_o = 0.
REQ-016 SHALL keep text_o and last_o stable while valid_o && !ready_i.
REQ-017 SHALL assert valid_o exactly in SEND; last_o = valid_o && index == 3.
REQ-018 SHALL, when IDLE receives done_i, load active from text_i, set index 0 and enter SEND; valid_o rises the next cycle (latency 1).
REQ-019 SHALL, when done_i arrives in SEND with no final transfer and pending empty, load pending from text_i.
REQ-020 SHALL, when done_i arrives in SEND with no final transfer and pending full, drop text_i and set ovf_o; active and pending are unchanged.
REQ-021 SHALL, on a final transfer (index 3) with pending full, load active from pending, set index 0 and stay in SEND with no bubble cycle; pending then loads text_i if done_i, else becomes empty.
REQ-022 SHALL, on a final transfer with pending empty, load active from text_i and stay in SEND if done_i; otherwise enter IDLE.
REQ-023 SHALL drive busy_o = active occupied || pending occupied, combinationally from registered state.
REQ-024 SHALL clear ovf_o only by reset.
REQ-025 SHALL produce no combinational path from ready_i or done_i to valid_o or busy_o.

Reset
REQ-026 SHALL, with rst = 0 at a clock edge, set state IDLE, index 0, both occupied flags 0 and ovf_o 0; text_o, valid_o, last_o and busy_o then read 0.
REQ-027 SHALL discard any block in flight when reset is asserted mid-operation; no partial word is emitted after reset.
REQ-028 SHALL ignore done_i in any cycle where rst = 0.

Structure
REQ-029 SHALL take the FSM state enum, the words-per-block constant (4) and the word width (32) from the shared package aes_pkg.
REQ-030 SHALL be a single module with no sub-modules; the word select is an inline mux.

Verification
REQ-031 SHALL cover: LSW_FIRST=1, done_i with text_i=128'h00112233_44556677_8899aabb_ccddeeff, ready_i=1 -> words ccddeeff, 8899aabb, 44556677, 00112233 on four consecutive cycles starting 1 cycle after done_i; last_o only on 00112233.
REQ-032 SHALL cover: LSW_FIRST=0, same block -> 00112233 first, ccddeeff last.
REQ-033 SHALL cover: ready_i low for 3 cycles during word 1 -> text_o stays 8899aabb and valid_o stays 1; sequence resumes unchanged.
REQ-034 SHALL cover: block B (all 32'hAAAAAAAA) arrives during word 1 of block A -> B queued in pending; B word 0 follows A word 3 with no gap; busy_o 1 throughout.
REQ-035 SHALL cover: ready_i=0, then three done_i strobes -> third block dropped, ovf_o=1 and stays 1; first two blocks are emitted intact.
REQ-036 SHALL cover: rst=0 asserted after word 2 -> next cycle valid_o=0, busy_o=0, ovf_o=0; a new done_i afterwards emits from word 0.
